// File: rtl/nested_select_fsm_if.sv
// -----------------------------------------------------------------------------
// nested_select_fsm_if
// Handshake and data bundle for the nested compare-and-select engine.
//
// Signals:
//   in_valid / in_ready          operation request / block can accept
//   a0, b0                       outer compare operands
//   a1, b1                       inner compare operands
//   outer_mode, inner_mode       compare mode (0 EQ, 1 NE, 2 LT, 3 GE; unsigned)
//   v_tt, v_tf, v_ft, v_ff       candidate values (outer/inner result)
//   out1                         selected value, held until next completion
//   out_valid                    one-cycle pulse when out1 is updated
//   done_count                   completed-operation counter (wraps)
//   fsm_state                    current state code (debug)
//
// Modports:
//   master - requester side (drives operands, observes results)
//   slave  - engine side
// -----------------------------------------------------------------------------
interface nested_select_fsm_if #(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a0;
    logic [WIDTH-1:0]     b0;
    logic [WIDTH-1:0]     a1;
    logic [WIDTH-1:0]     b1;
    logic [1:0]           outer_mode;
    logic [1:0]           inner_mode;
    logic [WIDTH-1:0]     v_tt;
    logic [WIDTH-1:0]     v_tf;
    logic [WIDTH-1:0]     v_ft;
    logic [WIDTH-1:0]     v_ff;
    logic [WIDTH-1:0]     out1;
    logic                 out_valid;
    logic [CNT_WIDTH-1:0] done_count;
    logic [2:0]           fsm_state;

    modport master (
        output in_valid, a0, b0, a1, b1, outer_mode, inner_mode,
               v_tt, v_tf, v_ft, v_ff,
        input  in_ready, out1, out_valid, done_count, fsm_state
    );

    modport slave (
        input  in_valid, a0, b0, a1, b1, outer_mode, inner_mode,
               v_tt, v_tf, v_ft, v_ff,
        output in_ready, out1, out_valid, done_count, fsm_state
    );
endinterface

// File: rtl/nested_select_fsm.sv
// -----------------------------------------------------------------------------
// nested_select_fsm
// Two-level compare-and-select engine. One operation is accepted in IDLE; the
// outer compare is evaluated in OUTER, the inner compare and the final select
// in INNER, and DONE carries the one-cycle out_valid pulse. One operation per
// four cycles; out1 and out_valid are visible after edge T+2 of handshake T.
//
// Ports:
//   clk    - system clock, rising edge
//   reset  - synchronous, active-high
//   bus    - nested_select_fsm_if.slave (handshake, operands, results)
// -----------------------------------------------------------------------------
module nested_select_fsm #(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    nested_select_fsm_if.slave    bus
);

    typedef enum logic [2:0] {
        S_INIT  = 3'd0,
        S_IDLE  = 3'd1,
        S_OUTER = 3'd2,
        S_INNER = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     a0_q, a0_d, b0_q, b0_d, a1_q, a1_d, b1_q, b1_d;
    logic [1:0]           omode_q, omode_d, imode_q, imode_d;
    logic [WIDTH-1:0]     vtt_q, vtt_d, vtf_q, vtf_d, vft_q, vft_d, vff_q, vff_d;
    logic                 flag_o_q, flag_o_d;
    logic [WIDTH-1:0]     out1_q, out1_d;
    logic                 out_valid_q, out_valid_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 flag_i;

    // Unsigned full-width compare selected by a 2-bit mode code.
    function automatic logic cmp(input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] b,
                                 input logic [1:0]       mode);
        case (mode)
            2'd0:    cmp = (a == b);
            2'd1:    cmp = (a != b);
            2'd2:    cmp = (a <  b);
            default: cmp = (a >= b);
        endcase
    endfunction

    assign flag_i = cmp(a1_q, b1_q, imode_q);

    always_comb begin
        state_d     = state_q;
        a0_d        = a0_q;
        b0_d        = b0_q;
        a1_d        = a1_q;
        b1_d        = b1_q;
        omode_d     = omode_q;
        imode_d     = imode_q;
        vtt_d       = vtt_q;
        vtf_d       = vtf_q;
        vft_d       = vft_q;
        vff_d       = vff_q;
        flag_o_d    = flag_o_q;
        out1_d      = out1_q;
        out_valid_d = 1'b0;
        cnt_d       = cnt_q;

        case (state_q)
            S_INIT: begin
                out1_d  = '0;
                state_d = S_IDLE;
            end
            S_IDLE: begin
                // Operands are only ever sampled here, so changes while an
                // operation is in flight cannot disturb it.
                if (bus.in_valid) begin
                    a0_d    = bus.a0;
                    b0_d    = bus.b0;
                    a1_d    = bus.a1;
                    b1_d    = bus.b1;
                    omode_d = bus.outer_mode;
                    imode_d = bus.inner_mode;
                    vtt_d   = bus.v_tt;
                    vtf_d   = bus.v_tf;
                    vft_d   = bus.v_ft;
                    vff_d   = bus.v_ff;
                    state_d = S_OUTER;
                end
            end
            S_OUTER: begin
                flag_o_d = cmp(a0_q, b0_q, omode_q);
                state_d  = S_INNER;
            end
            S_INNER: begin
                out1_d      = flag_o_q ? (flag_i ? vtt_q : vtf_q)
                                       : (flag_i ? vft_q : vff_q);
                out_valid_d = 1'b1;
                cnt_d       = cnt_q + CNT_WIDTH'(1);
                state_d     = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                // Unused codes recover through INIT.
                state_d = S_INIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_INIT;
            a0_q        <= '0;
            b0_q        <= '0;
            a1_q        <= '0;
            b1_q        <= '0;
            omode_q     <= '0;
            imode_q     <= '0;
            vtt_q       <= '0;
            vtf_q       <= '0;
            vft_q       <= '0;
            vff_q       <= '0;
            flag_o_q    <= 1'b0;
            out1_q      <= '0;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            a0_q        <= a0_d;
            b0_q        <= b0_d;
            a1_q        <= a1_d;
            b1_q        <= b1_d;
            omode_q     <= omode_d;
            imode_q     <= imode_d;
            vtt_q       <= vtt_d;
            vtf_q       <= vtf_d;
            vft_q       <= vft_d;
            vff_q       <= vff_d;
            flag_o_q    <= flag_o_d;
            out1_q      <= out1_d;
            out_valid_q <= out_valid_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.in_ready   = (state_q == S_IDLE);
    assign bus.out1       = out1_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.done_count = cnt_q;
    assign bus.fsm_state  = state_q;

endmodule

// File: tb/tb_nested_select_fsm.sv
module tb_nested_select_fsm;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_bad;
    int   exp_cnt;

    nested_select_fsm_if #(.WIDTH(32), .CNT_WIDTH(8)) bus ();
    nested_select_fsm_if #(.WIDTH(32), .CNT_WIDTH(2)) bus2 ();

    nested_select_fsm #(.WIDTH(32), .CNT_WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Narrow-counter copy driven by the same stimulus, for the wrap check.
    nested_select_fsm #(.WIDTH(32), .CNT_WIDTH(2)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    assign bus2.in_valid   = bus.in_valid;
    assign bus2.a0         = bus.a0;
    assign bus2.b0         = bus.b0;
    assign bus2.a1         = bus.a1;
    assign bus2.b1         = bus.b1;
    assign bus2.outer_mode = bus.outer_mode;
    assign bus2.inner_mode = bus.inner_mode;
    assign bus2.v_tt       = bus.v_tt;
    assign bus2.v_tf       = bus.v_tf;
    assign bus2.v_ft       = bus.v_ft;
    assign bus2.v_ff       = bus.v_ff;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input logic [31:0] a0, input logic [31:0] b0,
                           input logic [31:0] a1, input logic [31:0] b1,
                           input logic [1:0] om, input logic [1:0] im);
        bus.a0 = a0; bus.b0 = b0; bus.a1 = a1; bus.b1 = b1;
        bus.outer_mode = om; bus.inner_mode = im;
    endtask

    // One full operation from IDLE; checks timing, result and counter.
    task automatic do_op(input string tag,
                         input logic [31:0] a0, input logic [31:0] b0,
                         input logic [31:0] a1, input logic [31:0] b1,
                         input logic [1:0] om, input logic [1:0] im,
                         input logic [31:0] expv);
        int n;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check({tag, "_rdy"}, 32'(bus.in_ready), 32'd1);
        set_ops(a0, b0, a1, b1, om, im);
        bus.in_valid = 1'b1;
        step();                                   // edge T -> OUTER
        bus.in_valid = 1'b0;
        check({tag, "_busy"}, 32'(bus.in_ready), 32'd0);
        step();                                   // edge T+1 -> INNER
        check({tag, "_nopulse"}, 32'(bus.out_valid), 32'd0);
        step();                                   // edge T+2 -> DONE
        exp_cnt++;
        check({tag, "_vld"}, 32'(bus.out_valid), 32'd1);
        check({tag, "_out1"}, bus.out1, expv);
        check({tag, "_cnt"}, 32'(bus.done_count), 32'(exp_cnt % 256));
        step();                                   // edge T+3 -> IDLE
        check({tag, "_vldlow"}, 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        n_vec   = 0;
        n_bad   = 0;
        exp_cnt = 0;
        reset   = 1'b1;
        bus.in_valid = 1'b0;
        set_ops(32'd0, 32'd0, 32'd0, 32'd0, 2'd0, 2'd0);
        bus.v_tt = 32'd52;
        bus.v_tf = 32'd7;
        bus.v_ft = 32'd53;
        bus.v_ff = 32'd8;

        // Reset for two cycles, then INIT for one cycle, then IDLE.
        step();
        step();
        check("rst_state", 32'(bus.fsm_state), 32'd0);
        check("rst_rdy", 32'(bus.in_ready), 32'd0);
        check("rst_vld", 32'(bus.out_valid), 32'd0);
        check("rst_out1", bus.out1, 32'd0);
        check("rst_cnt", 32'(bus.done_count), 32'd0);
        reset = 1'b0;
        step();
        check("idle_state", 32'(bus.fsm_state), 32'd1);
        check("idle_rdy", 32'(bus.in_ready), 32'd1);
        check("idle_out1", bus.out1, 32'd0);
        check("idle_cnt", 32'(bus.done_count), 32'd0);

        // Basic selects.
        do_op("eqeq",  32'd10, 32'd0, 32'd20, 32'd100, 2'd0, 2'd0, 32'd8);
        do_op("nelt",  32'd10, 32'd0, 32'd20, 32'd100, 2'd1, 2'd2, 32'd52);
        do_op("eqge",  32'd10, 32'd0, 32'd20, 32'd100, 2'd0, 2'd3, 32'd8);
        do_op("eqeq0", 32'd0,  32'd0, 32'd20, 32'd100, 2'd0, 2'd0, 32'd7);

        // out1 holds through IDLE.
        step();
        step();
        check("hold_out1", bus.out1, 32'd7);

        // Boundary compares.
        do_op("lt_max", 32'd0, 32'hFFFF_FFFF, 32'd5, 32'd5, 2'd2, 2'd3, 32'd52);
        do_op("ge_max", 32'd0, 32'hFFFF_FFFF, 32'd5, 32'd5, 2'd3, 2'd0, 32'd53);
        do_op("lt_eq",  32'd0, 32'hFFFF_FFFF, 32'd5, 32'd5, 2'd2, 2'd2, 32'd7);
        do_op("ne_eq",  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5, 32'd5, 2'd1, 2'd1, 32'd8);

        // in_valid held high with operands changing every cycle.
        // Captured sets are 0, 4 and 8: outer NE vs 4, inner GE vs 8.
        begin
            logic [31:0] exp5 [3];
            exp5[0] = 32'd7;
            exp5[1] = 32'd8;
            exp5[2] = 32'd52;
            bus.in_valid = 1'b1;
            for (int c = 0; c < 12; c++) begin
                set_ops(32'(c), 32'd4, 32'(c), 32'd8, 2'd1, 2'd3);
                step();
                check($sformatf("stream_rdy%0d", c), 32'(bus.in_ready), 32'((c % 4) == 3));
                check($sformatf("stream_vld%0d", c), 32'(bus.out_valid), 32'((c % 4) == 2));
                if ((c % 4) == 2) begin
                    exp_cnt++;
                    check($sformatf("stream_out%0d", c), bus.out1, exp5[c / 4]);
                    check($sformatf("stream_cnt%0d", c), 32'(bus.done_count), 32'(exp_cnt % 256));
                end
            end
            bus.in_valid = 1'b0;
        end

        // Reset landing on the INNER edge aborts the operation.
        step();
        check("pre_abort_rdy", 32'(bus.in_ready), 32'd1);
        set_ops(32'd10, 32'd0, 32'd20, 32'd100, 2'd1, 2'd2);
        bus.in_valid = 1'b1;
        step();                                   // -> OUTER
        bus.in_valid = 1'b0;
        step();                                   // -> INNER
        check("abort_inner", 32'(bus.fsm_state), 32'd3);
        reset = 1'b1;
        bus.in_valid = 1'b1;
        step();
        check("abort_vld", 32'(bus.out_valid), 32'd0);
        check("abort_out1", bus.out1, 32'd0);
        check("abort_state", 32'(bus.fsm_state), 32'd0);
        check("abort_cnt", 32'(bus.done_count), 32'd0);
        check("abort_rdy", 32'(bus.in_ready), 32'd0);
        step();                                   // reset with in_valid: ignored
        check("rst_valid_state", 32'(bus.fsm_state), 32'd0);
        reset = 1'b0;
        bus.in_valid = 1'b0;
        step();
        check("post_abort_idle", 32'(bus.fsm_state), 32'd1);
        exp_cnt = 0;

        // Five operations: 8-bit counter reads 5, 2-bit counter wraps to 1.
        do_op("w1", 32'd1, 32'd1, 32'd1, 32'd2, 2'd0, 2'd2, 32'd52);
        do_op("w2", 32'd1, 32'd2, 32'd1, 32'd2, 2'd0, 2'd2, 32'd53);
        do_op("w3", 32'd3, 32'd2, 32'd3, 32'd2, 2'd3, 2'd2, 32'd7);
        do_op("w4", 32'd3, 32'd2, 32'd3, 32'd2, 2'd2, 2'd2, 32'd8);
        do_op("w5", 32'd3, 32'd3, 32'd9, 32'd9, 2'd3, 2'd1, 32'd7);
        check("wrap_cnt8", 32'(bus.done_count), 32'd5);
        check("wrap_cnt2", 32'(bus2.done_count), 32'd1);
        check("wrap_out2", bus2.out1, 32'd7);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/nested_select_fsm.md
Name: nested_select_fsm

Overview:
- Parametrised two-level compare-and-select engine built as an explicit state machine.
- Accepts one operation per handshake: an outer compare (a0 vs b0) and an inner compare (a1 vs b1), each with its own compare mode.
- Selects one of four candidate values from the two compare results and holds it on out1.
- Used as the generalised datapath target for nested if/else constructs that the compiler lowers to FSMs; an operation counter supports bench monitoring.

Parameters:
- WIDTH, 32, width of operands, candidate values and out1.
- CNT_WIDTH, 8, width of the completed-operation counter.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operation request.
- in_ready  output  1  block can accept an operation.
- a0, b0  input  WIDTH  outer compare operands.
- a1, b1  input  WIDTH  inner compare operands.
- outer_mode, inner_mode  input  2  compare mode: 0 EQ, 1 NE, 2 LT unsigned, 3 GE unsigned.
- v_tt, v_tf, v_ft, v_ff  input  WIDTH  candidate values, indexed as outer/inner result (t = true, f = false).
- out1  output  WIDTH  selected value; holds until the next completion.
- out_valid  output  1  one-cycle pulse when out1 is updated.
- done_count  output  CNT_WIDTH  number of completed operations.
- fsm_state  output  3  current state (debug).

Behaviour:
- Reset
  - Sampled on the clk edge. Next state is INIT.
  - Reset values: out1=0, out_valid=0, done_count=0, in_ready=0.
  - Clears all captured operands and flags.
- State encoding: INIT=0, IDLE=1, OUTER=2, INNER=3, DONE=4. Codes 5–7 are illegal and return to INIT on the next edge.
- INIT
  - Lasts exactly one cycle after reset deasserts.
  - out1 <= 0, then go to IDLE.
- IDLE
  - in_ready=1; in_ready is 0 in every other state (combinational from state).
  - On edge T with in_valid=1, capture all operands, modes and candidates, then go to OUTER.
  - With in_valid=0, stay in IDLE.
  - Inputs are not sampled outside IDLE, so changes during an operation have no effect.
- OUTER
  - Evaluate the captured outer compare at edge T+1, store it in flag_o, go to INNER.
- INNER
  - Evaluate the inner compare at edge T+2.
  - out1 <= (flag_o ? (flag_i ? v_tt : v_tf) : (flag_i ? v_ft : v_ff)).
  - out_valid <= 1, done_count <= done_count+1, go to DONE.
- DONE
  - out_valid=1 for this single cycle.
  - At edge T+3: out_valid <= 0, go to IDLE.
  - The next operation can be accepted at edge T+4 at the earliest.
  - Throughput is one operation per 4 cycles.
- Latency: handshake at edge T; out1 and out_valid are visible after edge T+2.
- Compares
  - All compares are unsigned, full WIDTH.
  - EQ/NE: bitwise equality.
  - LT: a<b. GE: a>=b.
  - Equal operands: EQ true, NE false, LT false, GE true.
  - Boundary values: 0 vs all-ones gives LT true, GE false.
- done_count wraps modulo 2^CNT_WIDTH: all-ones +1 gives 0, with no flag.
- out1 holds its value through IDLE and across any number of operations until the next INNER update.
- Reset mid-operation (in OUTER, INNER or DONE) aborts the operation.
  - No out_valid pulse is produced, even if reset coincides with the INNER edge.
  - All outputs return to reset values.
- Reset together with in_valid: reset wins and nothing is captured.

Test Plan:
1. Reset 2 cycles, release → INIT for 1 cycle, then IDLE; in_ready=1, out1=0, done_count=0.
2. a0=10, b0=0, a1=20, b1=100, both EQ, v_tt=52, v_tf=7, v_ft=53, v_ff=8 → out1=8 with out_valid one cycle after edge T+2; done_count=1.
3. Same operands with outer_mode=NE, inner_mode=LT → out1=52. Then outer_mode=EQ, inner_mode=GE → out1=8. Then a0=0 with EQ/EQ → out1=7.
4. Boundaries: a0=0, b0=0xFFFFFFFF with LT → true; GE → false. a1=b1=5 with GE → true.
5. in_valid held high continuously with operands changed every cycle → accepts only in IDLE (every 4 cycles); results match the captured operands; in_ready low in OUTER/INNER/DONE.
6. Reset asserted in the INNER cycle → no out_valid pulse, out1=0, state INIT. With CNT_WIDTH=2, 5 operations → done_count=1.
